// File: rtl/wave_sample_pwm_sink_pkg.sv
// Shared encodings and constants for the wave sample PWM sink.
package wave_sample_pwm_sink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Mid-scale offset mapping a signed Q0.n sample onto an unsigned duty value.
    function automatic int unsigned offset_const(input int unsigned n_frac);
        return 32'd1 << n_frac;
    endfunction

endpackage

// File: rtl/wave_sample_pwm_sink_pwm_modulator.sv
// Frame-based PWM: free-running frame counter, duty reload on frame boundary,
// registered compare output.
module wave_sample_pwm_sink_pwm_modulator
    import wave_sample_pwm_sink_pkg::*;
#(
    parameter int unsigned N_FRAC = 7
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_run,
    input  logic [N_FRAC:0] i_sample,
    output logic          o_pwm
);

    localparam int unsigned W = N_FRAC + 1;
    localparam logic [W-1:0] MID = W'(offset_const(N_FRAC));

    logic [W-1:0] r_pc;
    logic [W-1:0] r_duty;
    logic         r_pwm;
    logic         w_frame_end;
    logic [W-1:0] w_duty_next;

    assign w_frame_end = (r_pc == {W{1'b1}});
    assign w_duty_next = i_sample ^ MID;

    // Duty only changes on the last count of a frame so no frame is ever split.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc   <= '0;
            r_duty <= MID;
            r_pwm  <= 1'b0;
        end else if (!i_run) begin
            r_pc  <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_pc  <= r_pc + W'(1);
            r_pwm <= (r_pc < r_duty);
            if (w_frame_end) begin
                r_duty <= w_duty_next;
            end
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/wave_sample_pwm_sink.sv
// Sample-rate request FSM with timeout, sample capture and PWM output stage
// for an off-chip RC DAC.
module wave_sample_pwm_sink
    import wave_sample_pwm_sink_pkg::*;
#(
    parameter int unsigned N_FRAC    = 7,
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [DIV_WIDTH-1:0] sample_period_i,
    input  logic [N_FRAC:0]      data_i,
    input  logic                 data_valid_strobe_i,
    output logic                 get_next_data_strobe_o,
    output logic [N_FRAC:0]      sample_o,
    output logic                 sample_valid_strobe_o,
    output logic                 timeout_strobe_o,
    output logic                 pwm_o
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_period;
    logic [TO_W-1:0]      r_to_cnt;
    logic                 r_req;
    logic                 r_svs;
    logic                 r_to;
    logic [N_FRAC:0]      r_sample;

    logic [DIV_WIDTH-1:0] w_period_eff;
    logic                 w_tc;
    logic                 w_to_hit;
    logic                 w_req;
    logic                 w_cap;
    logic                 w_to;

    assign w_period_eff = (sample_period_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : sample_period_i;
    assign w_tc         = (r_div == (r_period - DIV_WIDTH'(1)));
    assign w_to_hit     = (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_COUNT;
                ST_COUNT: if (w_tc) w_state_nxt = ST_WAIT;
                ST_WAIT:  if (data_valid_strobe_i || w_to_hit) w_state_nxt = ST_COUNT;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // A valid strobe beats a coincident timeout; terminal counts during WAIT are dropped.
    always_comb begin
        w_req = 1'b0;
        w_cap = 1'b0;
        w_to  = 1'b0;
        if (enable_i) begin
            case (r_state)
                ST_COUNT: w_req = w_tc;
                ST_WAIT: begin
                    w_cap = data_valid_strobe_i;
                    w_to  = !data_valid_strobe_i && w_to_hit;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_div    <= '0;
            r_period <= DIV_WIDTH'(2);
            r_to_cnt <= '0;
            r_req    <= 1'b0;
            r_svs    <= 1'b0;
            r_to     <= 1'b0;
            r_sample <= '0;
        end else begin
            r_req <= w_req;
            r_svs <= w_cap;
            r_to  <= w_to;
            if (w_cap) begin
                r_sample <= data_i;
            end
            // Period is latched only at wrap (or while idle) so mid-period edits wait a cycle of P.
            if (!enable_i || (r_state == ST_IDLE)) begin
                r_div    <= '0;
                r_period <= w_period_eff;
            end else if (w_tc) begin
                r_div    <= '0;
                r_period <= w_period_eff;
            end else begin
                r_div <= r_div + DIV_WIDTH'(1);
            end
            if (w_req) begin
                r_to_cnt <= '0;
            end else if ((r_state == ST_WAIT) && !w_to_hit) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    wave_sample_pwm_sink_pwm_modulator #(
        .N_FRAC (N_FRAC)
    ) u_pwm (
        .i_clk    (clk_i),
        .i_rst_n  (rst_i),
        .i_run    (enable_i),
        .i_sample (r_sample),
        .o_pwm    (pwm_o)
    );

    assign get_next_data_strobe_o = r_req;
    assign sample_valid_strobe_o  = r_svs;
    assign timeout_strobe_o       = r_to;
    assign sample_o               = r_sample;

endmodule

// File: tb/tb_wave_sample_pwm_sink.sv
// Scoreboard bench: a phase-level predictor fills expected-event queues, a
// responder plays the generator, and a monitor checks DUT events and PWM frames.
module tb_wave_sample_pwm_sink;

    localparam int unsigned N_FRAC    = 7;
    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned TIMEOUT   = 15;
    localparam int          RESP_N    = 4096;
    localparam int          GAP       = 20;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [15:0] sample_period_i;
    logic [7:0]  data_i;
    logic        data_valid_strobe_i;
    logic        get_next_data_strobe_o;
    logic [7:0]  sample_o;
    logic        sample_valid_strobe_o;
    logic        timeout_strobe_o;
    logic        pwm_o;

    logic        gen_stb = 1'b0;
    logic        man_stb = 1'b0;
    logic [7:0]  gen_data = 8'h00;
    logic [7:0]  man_data = 8'h00;

    assign data_valid_strobe_i = gen_stb | man_stb;
    assign data_i              = man_stb ? man_data : gen_data;

    wave_sample_pwm_sink #(
        .N_FRAC    (N_FRAC),
        .DIV_WIDTH (DIV_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .enable_i               (enable_i),
        .sample_period_i        (sample_period_i),
        .data_i                 (data_i),
        .data_valid_strobe_i    (data_valid_strobe_i),
        .get_next_data_strobe_o (get_next_data_strobe_o),
        .sample_o               (sample_o),
        .sample_valid_strobe_o  (sample_valid_strobe_o),
        .timeout_strobe_o       (timeout_strobe_o),
        .pwm_o                  (pwm_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    // Generator response per request: delay in cycles (-1 = never answers) and data.
    int         resp_d [RESP_N];
    logic [7:0] resp_v [RESP_N];
    int         gen_idx  = 0;
    int         pred_idx = 0;

    int         exp_req_q[$];
    int         exp_to_q[$];
    int         exp_smp_cyc_q[$];
    logic [7:0] exp_smp_val_q[$];

    int         ph_s = -1000;
    int         ph_d = -1000;
    int         rst_cyc = -1;
    logic [7:0] held = 8'h00;
    int         cur_duty = 128;
    int         next_duty = 128;
    int         hi_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic set_resp(input int off, input int d, input logic [7:0] v);
        resp_d[(pred_idx + off) % RESP_N] = d;
        resp_v[(pred_idx + off) % RESP_N] = v;
    endtask

    // Requests land every P cycles after enable unless one is still outstanding.
    task automatic predict(input int s, input int d_end, input int p_raw);
        int p;
        int busy;
        int rd;
        logic [7:0] rv;
        p = (p_raw < 2) ? 2 : p_raw;
        busy = s - 1;
        for (int t = s + p; t < d_end; t += p) begin
            if (busy <= t - 1) begin
                rd = resp_d[pred_idx % RESP_N];
                rv = resp_v[pred_idx % RESP_N];
                pred_idx++;
                exp_req_q.push_back(t);
                if (rd >= 0 && rd < int'(TIMEOUT)) begin
                    busy = t + rd + 1;
                    if (busy < d_end) begin
                        exp_smp_cyc_q.push_back(busy);
                        exp_smp_val_q.push_back(rv);
                    end
                end else begin
                    busy = t + int'(TIMEOUT);
                    if (busy < d_end) exp_to_q.push_back(busy);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            cyc = cyc + 1;
        end
    end

    // Generator model: answers the k-th observed request with table entry k.
    initial begin
        int  g_cnt;
        bit  g_act;
        logic [7:0] g_val;
        g_cnt = 0;
        g_act = 1'b0;
        g_val = 8'h00;
        forever begin
            @(posedge clk_i);
            #1;
            gen_stb = 1'b0;
            if (enable_i !== 1'b1 || rst_i !== 1'b1) begin
                g_act = 1'b0;
            end else if (get_next_data_strobe_o === 1'b1) begin
                g_cnt = resp_d[gen_idx % RESP_N];
                g_val = resp_v[gen_idx % RESP_N];
                gen_idx++;
                g_act = (g_cnt >= 0);
            end
            if (g_act) begin
                if (g_cnt == 0) begin
                    gen_stb  = 1'b1;
                    gen_data = g_val;
                    g_act    = 1'b0;
                end else begin
                    g_cnt--;
                end
            end
        end
    end

    task automatic mon_step();
        int p;
        int ec;
        logic [7:0] ev;
        if (cyc == rst_cyc) begin
            held = 8'h00;
            cur_duty = 128;
        end
        if (get_next_data_strobe_o === 1'b1) begin
            ec = (exp_req_q.size() > 0) ? exp_req_q.pop_front() : -1;
            check("request_cycle", cyc, ec);
        end
        if (timeout_strobe_o === 1'b1) begin
            ec = (exp_to_q.size() > 0) ? exp_to_q.pop_front() : -1;
            check("timeout_cycle", cyc, ec);
        end
        if (sample_valid_strobe_o === 1'b1) begin
            if (exp_smp_cyc_q.size() > 0) begin
                ec = exp_smp_cyc_q.pop_front();
                ev = exp_smp_val_q.pop_front();
                check("sample_cycle", cyc, ec);
                check("sample_data", 32'(sample_o), 32'(ev));
                held = ev;
            end else begin
                check("sample_cycle", cyc, -1);
            end
        end else begin
            check("sample_hold", 32'(sample_o), 32'(held));
        end
        // Frame model: each 256-cycle frame from enable shows exactly the duty latched before it.
        if (cyc >= ph_s && cyc < ph_d) begin
            p = (cyc - ph_s) % 256;
            if (p == 0) hi_cnt = 0;
            if (pwm_o === 1'b1) hi_cnt++;
            if (p == 254) next_duty = int'(held ^ 8'h80);
            if (p == 255) begin
                check("pwm_frame_high", hi_cnt, cur_duty);
                cur_duty = next_duty;
            end
        end else begin
            check("pwm_idle", 32'(pwm_o), 0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_i);
            if (cyc >= 1) mon_step();
        end
    end

    task automatic run_phase(input int p_raw, input int n, input int man_off, input logic [7:0] man_v,
                             input int late_off, input logic [7:0] late_v, input bit end_rst);
        int s;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        sample_period_i = 16'(p_raw);
        enable_i = 1'b1;
        s = cyc + 1;
        ph_s = s;
        ph_d = s + n;
        predict(s, s + n, p_raw);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            man_stb  = (i == man_off);
            man_data = man_v;
        end
        enable_i = 1'b0;
        if (end_rst) begin
            rst_i = 1'b0;
            rst_cyc = s + n;
        end
        for (int g = 0; g < GAP; g++) begin
            @(posedge clk_i);
            #1;
            man_stb  = (g == late_off);
            man_data = late_v;
        end
        man_stb = 1'b0;
        check("requests_missing", exp_req_q.size(), 0);
        check("samples_missing", exp_smp_cyc_q.size(), 0);
        check("timeouts_missing", exp_to_q.size(), 0);
        exp_req_q.delete();
        exp_to_q.delete();
        exp_smp_cyc_q.delete();
        exp_smp_val_q.delete();
    endtask

    initial begin
        rst_i = 1'b0;
        enable_i = 1'b0;
        sample_period_i = 16'd10;
        for (int i = 0; i < RESP_N; i++) begin
            resp_d[i] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1));
            resp_v[i] = 8'($urandom);
        end
        repeat (3) @(posedge clk_i);

        // Period 10, generator answers 0x00 two cycles after each request.
        for (int k = 0; k < 60; k++) set_resp(k, 2, 8'h00);
        run_phase(10, 532, -1, 8'h00, -1, 8'h00, 1'b0);

        // Full-scale negative then positive samples captured mid-frame.
        set_resp(0, 2, 8'h80);
        for (int k = 1; k < 6; k++) set_resp(k, 2, 8'h7F);
        run_phase(300, 1034, -1, 8'h00, -1, 8'h00, 1'b0);

        // Timeout, valid-at-timeout, then unsolicited strobe in COUNT.
        set_resp(0, -1, 8'hEE);
        set_resp(1, 14, 8'h33);
        set_resp(2, 3, 8'h44);
        run_phase(40, 200, 100, 8'h55, -1, 8'h00, 1'b0);

        // Period 4 with response delay 6: alternate terminal counts are skipped.
        for (int k = 0; k < 40; k++) set_resp(k, 6, 8'($urandom));
        run_phase(4, 120, -1, 8'h00, -1, 8'h00, 1'b0);

        // Disable while waiting, then a late strobe with 0x20 while idle.
        set_resp(0, -1, 8'h00);
        run_phase(10, 15, -1, 8'h00, 2, 8'h20, 1'b0);

        // Re-enable: first request one period after enable.
        run_phase(10, 100, -1, 8'h00, -1, 8'h00, 1'b0);

        // Randomized periods (including 0 and 1), delays, drops and data.
        for (int r = 0; r < 6; r++) begin
            run_phase(int'($urandom_range(0, 24)), int'($urandom_range(150, 600)),
                      -1, 8'h00, -1, 8'h00, 1'b0);
        end

        // Reset mid-frame, then duty must restart at mid-scale.
        run_phase(7, 300, -1, 8'h00, -1, 8'h00, 1'b1);
        run_phase(9, 300, -1, 8'h00, -1, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
